// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg
//   Shared definitions for the bit-serial subtractor: FSM state
//   encoding and the default operand width.
package serial_subtractor_pkg;

    localparam int unsigned SS_DEFAULT_WIDTH = 8;
    localparam int unsigned SS_DEFAULT_CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } ss_state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// full_subtractor
//   Single-bit combinational full subtractor: d = x - y - bin.
//   Ports:
//     x    : minuend bit
//     y    : subtrahend bit
//     bin  : borrow in
//     d    : difference bit
//     bout : borrow out
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial unsigned subtractor. Computes a - b modulo 2^WIDTH, one
//   bit per clock, LSB first, through a single full-subtractor cell with
//   a registered borrow. Start/ready/done handshake; all outputs are
//   registered.
//   Ports:
//     clk        : rising-edge clock
//     rst        : synchronous active-high reset
//     start      : request, sampled only while ready=1
//     a, b       : minuend / subtrahend, captured on the accepting edge
//     ready      : high in IDLE
//     busy       : high while bits are being processed
//     done       : one-cycle pulse when diff/borrow_out are final
//     diff       : a - b mod 2^WIDTH, held until the next accepted start
//     borrow_out : final borrow (1 when a < b), held with diff
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = SS_DEFAULT_WIDTH,
    parameter int unsigned CNT_W = SS_DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    ss_state_t        r_state;
    ss_state_t        w_state_next;

    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_diff;
    logic [CNT_W-1:0] r_cnt;
    logic             r_bw;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;

    logic             w_d;
    logic             w_bout;
    logic             w_last_bit;

    full_subtractor u_fs (
        .x    (r_sa[0]),
        .y    (r_sb[0]),
        .bin  (r_bw),
        .d    (w_d),
        .bout (w_bout)
    );

    assign w_last_bit = (r_cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start)      w_state_next = S_SHIFT;
            S_SHIFT: if (w_last_bit) w_state_next = S_DONE;
            S_DONE:                  w_state_next = S_IDLE;
            default:                 w_state_next = S_IDLE;
        endcase
    end

    // Handshake flags are registered from the next state so they line
    // up exactly with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sa    <= '0;
            r_sb    <= '0;
            r_diff  <= '0;
            r_cnt   <= '0;
            r_bw    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ready <= (w_state_next == S_IDLE);
            r_busy  <= (w_state_next == S_SHIFT);
            r_done  <= (w_state_next == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sa   <= a;
                        r_sb   <= b;
                        r_bw   <= 1'b0;
                        r_cnt  <= '0;
                        r_diff <= '0;
                    end
                end
                S_SHIFT: begin
                    // Result bits enter at the MSB so that after WIDTH
                    // shifts the first (LSB) result bit sits at bit 0.
                    r_diff <= {w_d, r_diff[WIDTH-1:1]};
                    r_sa   <= r_sa >> 1;
                    r_sb   <= r_sb >> 1;
                    r_bw   <= w_bout;
                    r_cnt  <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign ready      = r_ready;
    assign busy       = r_busy;
    assign done       = r_done;
    assign diff       = r_diff;
    assign borrow_out = r_bw;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    localparam int WIDTH = 8;
    localparam int LAT   = WIDTH + 1;  // negedges from accept sample to done sample
    localparam int PERIOD = WIDTH + 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             ready, busy, done, borrow_out;
    logic [WIDTH-1:0] diff;

    serial_subtractor #(.WIDTH(WIDTH), .CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .ready      (ready),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic             bo;
        int               acc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   n_pushed = 0;
    int   n_done = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: compares every done pulse against the scoreboard head.
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (prev_done) chk("ready_after_done", {31'd0, ready}, 32'd1);
        if (done) begin
            n_done = n_done + 1;
            chk("ready_low_in_done", {31'd0, ready}, 32'd0);
            chk("busy_low_in_done", {31'd0, busy}, 32'd0);
            if (q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("diff", {24'd0, diff}, {24'd0, e.d});
                chk("borrow_out", {31'd0, borrow_out}, {31'd0, e.bo});
                chk("latency", cyc - e.acc, LAT);
            end
        end
        prev_done = done;
    end

    task automatic push_exp(input logic [WIDTH-1:0] ea, input logic [WIDTH-1:0] eb,
                            input logic [WIDTH-1:0] ed, input logic ebo);
        exp_t e;
        e.d   = ed;
        e.bo  = ebo;
        e.acc = cyc;
        q.push_back(e);
        n_pushed = n_pushed + 1;
    endtask

    // Called at a negedge; raises start until the DUT is ready, then
    // records the expected (hand-computed) result.
    task automatic do_op(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                         input logic [WIDTH-1:0] ed, input logic ebo);
        int t = 0;
        a = ia;
        b = ib;
        start = 1'b1;
        while (!ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!ready) chk("ready_timeout", 32'd0, 32'd1);
        else        push_exp(ia, ib, ed, ebo);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("drain_timeout", q.size(), 0);
        @(negedge clk);
    endtask

    int last_acc;
    int t;

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_diff", {24'd0, diff}, 32'd0);
        chk("rst_borrow", {31'd0, borrow_out}, 32'd0);

        // Directed vectors with hand-computed results
        do_op(8'h05, 8'h03, 8'h02, 1'b0);
        chk("busy_in_shift", {31'd0, busy}, 32'd1);
        drain();
        do_op(8'h03, 8'h05, 8'hFE, 1'b1); drain();
        do_op(8'h00, 8'h01, 8'hFF, 1'b1); drain();
        do_op(8'hA5, 8'hA5, 8'h00, 1'b0); drain();
        do_op(8'hFF, 8'h00, 8'hFF, 1'b0); drain();

        // Start while busy is ignored
        do_op(8'h80, 8'h01, 8'h7F, 1'b0);
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; start = 1'b1;
        chk("ready_low_busy", {31'd0, ready}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (12) @(negedge clk);

        // Reset in the middle of an operation: no done, outputs cleared
        a = 8'h10; b = 8'h20; start = 1'b1;
        t = 0;
        while (!ready && t < 100) begin @(negedge clk); t++; end
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready", {31'd0, ready}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_diff", {24'd0, diff}, 32'd0);
        chk("abort_borrow", {31'd0, borrow_out}, 32'd0);
        repeat (12) @(negedge clk);
        do_op(8'h20, 8'h10, 8'h10, 1'b0); drain();

        // start held high: one accept every PERIOD cycles
        a = 8'h09; b = 8'h04; start = 1'b1;
        last_acc = -1;
        for (int k = 0; k < 4; k++) begin
            t = 0;
            while (!ready && t < 100) begin @(negedge clk); t++; end
            if (!ready) chk("cont_timeout", 32'd0, 32'd1);
            else begin
                if (last_acc >= 0) chk("cont_period", cyc - last_acc, PERIOD);
                last_acc = cyc;
                push_exp(8'h09, 8'h04, 8'h05, 1'b0);
            end
            @(negedge clk);
        end
        start = 1'b0;
        drain();
        repeat (15) @(negedge clk);

        chk("queue_empty", q.size(), 0);
        chk("done_count", n_done, n_pushed);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
